// File: rtl/cam_capture.sv
// OV7670 RGB444 capture: packs byte pairs from the camera bus into 12-bit pixels
// and writes them into the pixel FIFO, with frame skipping and size/overflow monitoring.
module cam_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 1
) (
    input  logic        i_p_clk,
    input  logic        i_rstn,
    input  logic        i_cfg_done,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic        o_wr,
    output logic [11:0] o_wdata,
    input  logic        i_full,
    output logic        o_sof,
    output logic        o_overflow,
    output logic        o_size_err,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [9:0] H_LEN     = 10'(H_ACTIVE);
    localparam logic [9:0] V_LEN     = 10'(V_ACTIVE);
    localparam logic [3:0] SKIP_INIT = 4'(SKIP_FRAMES);

    typedef enum logic [1:0] {WAIT_CFG, SKIP, CAPTURE} state_t;

    state_t      state_reg, state_next;
    logic        vsync_q_reg;
    logic        href_q_reg;
    logic        phase_reg, phase_next;
    logic [3:0]  hi_reg, hi_next;
    logic [3:0]  skip_cnt_reg, skip_cnt_next;
    logic [9:0]  x_reg, x_next;
    logic [9:0]  y_reg, y_next;

    logic sof_edge, href_fall;
    logic cap_en, cap_sof, chk_frame;
    logic pix_formed, line_err, frame_err;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign sof_edge  = vsync_q_reg & ~i_vsync;
    assign href_fall = href_q_reg & ~i_href;

    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            state_reg <= WAIT_CFG;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_CFG: if (i_cfg_done) state_next = SKIP;
            SKIP:     if (sof_edge && skip_cnt_reg == 4'd0) state_next = CAPTURE;
            CAPTURE:  if (!i_cfg_done) state_next = WAIT_CFG;
            default:  state_next = WAIT_CFG;
        endcase
    end

    // The edge that moves SKIP into CAPTURE is itself the first captured frame start.
    always_comb begin
        cap_en    = 1'b0;
        cap_sof   = 1'b0;
        chk_frame = 1'b0;
        case (state_reg)
            SKIP: begin
                if (sof_edge && skip_cnt_reg == 4'd0) begin
                    cap_en  = 1'b1;
                    cap_sof = 1'b1;
                end
            end
            CAPTURE: begin
                if (i_cfg_done) begin
                    cap_en    = 1'b1;
                    cap_sof   = sof_edge;
                    chk_frame = sof_edge;
                end
            end
            default: ;
        endcase
    end

    assign pix_formed = cap_en & i_href & phase_reg;
    assign line_err   = cap_en & href_fall & ~cap_sof & (x_reg != H_LEN);
    assign frame_err  = chk_frame & (y_reg != V_LEN);

    always_comb begin
        phase_next    = (cap_en & i_href) ? ~phase_reg : 1'b0;
        hi_next       = (cap_en & i_href & ~phase_reg) ? i_data[3:0] : hi_reg;
        skip_cnt_next = skip_cnt_reg;
        if (state_reg == WAIT_CFG && i_cfg_done) begin
            skip_cnt_next = SKIP_INIT;
        end else if (state_reg == SKIP && sof_edge && skip_cnt_reg != 4'd0) begin
            skip_cnt_next = skip_cnt_reg - 4'd1;
        end

        // Frame start clears first, so a byte coincident with it lands in the new frame.
        x_next = x_reg;
        y_next = y_reg;
        if (cap_sof) begin
            x_next = 10'd0;
            y_next = 10'd0;
        end else if (cap_en && href_fall) begin
            x_next = 10'd0;
            y_next = sat_inc(y_reg);
        end
        if (pix_formed) begin
            x_next = sat_inc(x_next);
        end
    end

    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            vsync_q_reg  <= 1'b0;
            href_q_reg   <= 1'b0;
            phase_reg    <= 1'b0;
            hi_reg       <= 4'd0;
            skip_cnt_reg <= 4'd0;
            x_reg        <= 10'd0;
            y_reg        <= 10'd0;
            o_wr         <= 1'b0;
            o_wdata      <= 12'd0;
            o_sof        <= 1'b0;
            o_overflow   <= 1'b0;
            o_size_err   <= 1'b0;
            o_frame_cnt  <= 8'd0;
        end else begin
            vsync_q_reg  <= i_vsync;
            href_q_reg   <= i_href;
            phase_reg    <= phase_next;
            hi_reg       <= hi_next;
            skip_cnt_reg <= skip_cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            o_wr         <= pix_formed & ~i_full;
            if (pix_formed && !i_full) begin
                o_wdata <= {hi_reg, i_data};
            end
            o_sof        <= cap_sof;
            o_overflow   <= o_overflow | (pix_formed & i_full);
            o_size_err   <= o_size_err | line_err | frame_err;
            o_frame_cnt  <= o_frame_cnt + {7'd0, chk_frame};
        end
    end

endmodule
